// File: rtl/codec_config_sequencer.sv
// Brings the SSM2603 codec from reset to playback by walking a 12-entry register init table
// over the codec controller's write/busy handshake. Define READBACK_VERIFY_EN to read back and verify each write.
module codec_config_sequencer #(
    parameter int ADDR_W       = 7,
    parameter int DATA_W       = 9,
    parameter int POWERUP_WAIT = 1024,
    parameter int TIMEOUT      = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        frequency,
    output logic              codec_wr_en,
    output logic              codec_rd_en,
    output logic [ADDR_W-1:0] codec_reg_addr,
    output logic [DATA_W-1:0] codec_data_wr,
    input  logic [DATA_W-1:0] codec_data_rd,
    input  logic              controller_busy,
    output logic              output_en,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              seq_error,
    output logic [3:0]        step
);

    localparam int CNT_MAX = (TIMEOUT > POWERUP_WAIT) ? TIMEOUT : POWERUP_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(POWERUP_WAIT - 1);

    localparam logic [6:0] INIT_ADDR [12] = '{
        7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03,
        7'h04, 7'h05, 7'h07, 7'h08, 7'h09, 7'h06
    };
    localparam logic [8:0] INIT_DATA [12] = '{
        9'h000, 9'h072, 9'h017, 9'h017, 9'h079, 9'h079,
        9'h010, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h062
    };

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
`ifdef READBACK_VERIFY_EN
        S_RD_ISSUE,
        S_RD_ACK,
        S_RD_DONE,
        S_CHECK,
`endif
        S_NEXT,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_reg;
    logic [4:0]        freq_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] tbl_addr [16];
    logic [DATA_W-1:0] tbl_data [16];

    // Entry 9 carries the sample-rate code captured at start; slots 12..15 are never addressed.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rom
            if (gi == 9) begin : g_rate
                assign tbl_addr[gi] = ADDR_W'(INIT_ADDR[gi]);
                assign tbl_data[gi] = DATA_W'({3'b000, freq_reg, 1'b0});
            end else if (gi < 12) begin : g_const
                assign tbl_addr[gi] = ADDR_W'(INIT_ADDR[gi]);
                assign tbl_data[gi] = DATA_W'(INIT_DATA[gi]);
            end else begin : g_pad
                assign tbl_addr[gi] = '0;
                assign tbl_data[gi] = '0;
            end
        end
    endgenerate

`ifdef READBACK_VERIFY_EN
    logic [DATA_W-1:0] rd_data_reg;
`else
    logic unused_rd;
    assign unused_rd   = ^codec_data_rd;
    assign codec_rd_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            freq_reg       <= '0;
            cnt_reg        <= '0;
            step           <= '0;
            codec_wr_en    <= 1'b0;
            codec_reg_addr <= '0;
            codec_data_wr  <= '0;
            output_en      <= 1'b0;
            seq_busy       <= 1'b0;
            seq_done       <= 1'b0;
            seq_error      <= 1'b0;
`ifdef READBACK_VERIFY_EN
            codec_rd_en    <= 1'b0;
            rd_data_reg    <= '0;
`endif
        end else begin
            codec_wr_en <= 1'b0;
`ifdef READBACK_VERIFY_EN
            codec_rd_en <= 1'b0;
`endif
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        freq_reg  <= frequency;
                        step      <= '0;
                        output_en <= 1'b0;
                        seq_done  <= 1'b0;
                        seq_error <= 1'b0;
                        seq_busy  <= 1'b1;
                        state_reg <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!controller_busy) begin
                        codec_reg_addr <= tbl_addr[step];
                        codec_data_wr  <= tbl_data[step];
                        codec_wr_en    <= 1'b1;
                        cnt_reg        <= '0;
                        state_reg      <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (controller_busy) begin
                        cnt_reg   <= '0;
                        state_reg <= S_WAIT_DONE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        seq_error <= 1'b1;
                        output_en <= 1'b0;
                        seq_busy  <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!controller_busy) begin
                        cnt_reg   <= '0;
`ifdef READBACK_VERIFY_EN
                        // Register 0x0F (soft reset) cannot be read back.
                        state_reg <= (step != 4'd0) ? S_RD_ISSUE : S_NEXT;
`else
                        state_reg <= S_NEXT;
`endif
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        seq_error <= 1'b1;
                        output_en <= 1'b0;
                        seq_busy  <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
`ifdef READBACK_VERIFY_EN
                S_RD_ISSUE: begin
                    if (!controller_busy) begin
                        codec_rd_en <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= S_RD_ACK;
                    end
                end
                S_RD_ACK: begin
                    if (controller_busy) begin
                        cnt_reg   <= '0;
                        state_reg <= S_RD_DONE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        seq_error <= 1'b1;
                        output_en <= 1'b0;
                        seq_busy  <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_RD_DONE: begin
                    if (!controller_busy) begin
                        rd_data_reg <= codec_data_rd;
                        state_reg   <= S_CHECK;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        seq_error <= 1'b1;
                        output_en <= 1'b0;
                        seq_busy  <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (rd_data_reg != tbl_data[step]) begin
                        seq_error <= 1'b1;
                        output_en <= 1'b0;
                        seq_busy  <= 1'b0;
                        state_reg <= S_ERROR;
                    end else begin
                        state_reg <= S_NEXT;
                    end
                end
`endif
                S_NEXT: begin
                    cnt_reg <= '0;
                    // Power-up waits follow the soft reset and precede the final output power-up.
                    if (step == 4'd0 || step == 4'd10) begin
                        state_reg <= S_DELAY;
                    end else if (step == 4'd11) begin
                        seq_done  <= 1'b1;
                        output_en <= 1'b1;
                        seq_busy  <= 1'b0;
                        state_reg <= S_DONE;
                    end else begin
                        step      <= step + 4'd1;
                        state_reg <= S_ISSUE;
                    end
                end
                S_DELAY: begin
                    if (cnt_reg == DELAY_LAST) begin
                        step      <= step + 4'd1;
                        state_reg <= S_ISSUE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Randomized bench for codec_config_sequencer: a busy-handshake responder plus a table-driven write model.
module tb_codec_config_sequencer;

    localparam int PW = 40;
    localparam int TO = 300;
    localparam int PERIOD = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] frequency;
    logic       codec_wr_en, codec_rd_en;
    logic [6:0] codec_reg_addr;
    logic [8:0] codec_data_wr, codec_data_rd;
    logic       controller_busy;
    logic       output_en, seq_busy, seq_done, seq_error;
    logic [3:0] step;

    codec_config_sequencer #(
        .ADDR_W(7), .DATA_W(9), .POWERUP_WAIT(PW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frequency(frequency),
        .codec_wr_en(codec_wr_en), .codec_rd_en(codec_rd_en),
        .codec_reg_addr(codec_reg_addr), .codec_data_wr(codec_data_wr),
        .codec_data_rd(codec_data_rd), .controller_busy(controller_busy),
        .output_en(output_en), .seq_busy(seq_busy), .seq_done(seq_done),
        .seq_error(seq_error), .step(step)
    );

    always #(PERIOD / 2) clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected write stream and what was observed in the current run.
    logic [6:0] exp_addr [12];
    logic [8:0] exp_data [12];
    logic [6:0] obs_addr [12];
    logic [8:0] obs_data [12];
    longint     obs_t    [12];
    int         wr_idx = 0;
    int         rd_cnt = 0;
    logic [6:0] last_wr_addr = '0;
    bit         quiet = 0;

    // Responder controls.
    bit         drop_en = 0;
    logic [6:0] drop_addr = '0;
    bit         corrupt_en = 0;
    logic [8:0] mem [128];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void build_model(input logic [4:0] f);
        logic [6:0] a [12] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03,
                               7'h04, 7'h05, 7'h07, 7'h08, 7'h09, 7'h06};
        logic [8:0] d [12] = '{9'h000, 9'h072, 9'h017, 9'h017, 9'h079, 9'h079,
                               9'h010, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h062};
        for (int i = 0; i < 12; i++) begin
            exp_addr[i] = a[i];
            exp_data[i] = d[i];
        end
        exp_data[9] = {3'b000, f, 1'b0};
    endfunction

    // Codec controller model: random ack latency (0 = same cycle as the write) and busy length.
    initial begin
        logic       is_rd;
        logic [6:0] a;
        int         dly, blen;
        controller_busy = 1'b0;
        codec_data_rd   = '0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (codec_wr_en || codec_rd_en) begin
                is_rd = codec_rd_en;
                a     = codec_reg_addr;
                if (!is_rd) mem[a] = codec_data_wr;
                if (!(!is_rd && drop_en && a == drop_addr)) begin
                    dly  = $urandom_range(0, 3);
                    blen = $urandom_range(1, 4);
                    repeat (dly) @(negedge clk);
                    controller_busy = 1'b1;
                    repeat (blen) @(negedge clk);
                    if (is_rd) codec_data_rd = (corrupt_en && a == 7'h00) ? 9'h016 : mem[a];
                    controller_busy = 1'b0;
                end
            end
        end
    end

    // Compare process: every write against the model, plus per-cycle output invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) chk("oe_tracks_done", output_en, seq_done);
`ifndef READBACK_VERIFY_EN
            chk("rd_en_low", codec_rd_en, 1'b0);
`endif
            if (quiet) chk("no_wr_after_reset", codec_wr_en, 1'b0);
            else if (codec_wr_en) begin
                if (wr_idx < 12) begin
                    chk("wr_addr", codec_reg_addr, exp_addr[wr_idx]);
                    chk("wr_data", codec_data_wr, exp_data[wr_idx]);
                    chk("wr_step", step, wr_idx);
                    obs_addr[wr_idx] = codec_reg_addr;
                    obs_data[wr_idx] = codec_data_wr;
                    obs_t[wr_idx]    = $time;
                    if (wr_idx == 1 || wr_idx == 11)
                        chk("powerup_gap", ((obs_t[wr_idx] - obs_t[wr_idx-1]) / PERIOD) >= PW, 1'b1);
                    last_wr_addr = codec_reg_addr;
                    wr_idx++;
                end else begin
                    chk("extra_write", wr_idx + 1, 12);
                end
            end
            if (codec_rd_en) begin
                chk("rd_addr", codec_reg_addr, last_wr_addr);
                rd_cnt++;
            end
        end
    end

    task automatic do_start(input logic [4:0] f);
        build_model(f);
        wr_idx = 0;
        rd_cnt = 0;
        frequency = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        $display("start: frequency=0x%0h", f);
    endtask

    task automatic wait_flag(input bit want_err, input int bound, output bit got);
        got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((!want_err && seq_done) || (want_err && seq_error)) begin
                got = 1;
                break;
            end
        end
        chk(want_err ? "wait_error" : "wait_done", got, 1'b1);
    endtask

    task automatic check_done(input string tag);
        chk({tag, "_done"}, seq_done, 1'b1);
        chk({tag, "_oe"}, output_en, 1'b1);
        chk({tag, "_busy"}, seq_busy, 1'b0);
        chk({tag, "_err"}, seq_error, 1'b0);
        chk({tag, "_step"}, step, 4'd11);
        chk({tag, "_writes"}, wr_idx, 12);
`ifdef READBACK_VERIFY_EN
        chk({tag, "_reads"}, rd_cnt, 11);
`endif
        $display("%s: sequence done, %0d writes, %0d reads", tag, wr_idx, rd_cnt);
    endtask

    task automatic run_full(input logic [4:0] f, input string tag);
        bit got;
        do_start(f);
        wait_flag(1'b0, 3000, got);
        check_done(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         got;
        longint     err_t;
        int         lat;
        logic [4:0] f1, f2;
        reset = 1'b1;
        start = 1'b0;
        frequency = '0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", codec_wr_en, 1'b0);
        chk("rst_rd_en", codec_rd_en, 1'b0);
        chk("rst_addr", codec_reg_addr, 7'h00);
        chk("rst_data", codec_data_wr, 9'h000);
        chk("rst_oe", output_en, 1'b0);
        chk("rst_busy", seq_busy, 1'b0);
        chk("rst_done", seq_done, 1'b0);
        chk("rst_err", seq_error, 1'b0);
        chk("rst_step", step, 4'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic bring-up at frequency 0, then the 0x03 rate code.
        run_full(5'h00, "A");
        chk("A_w9_data", obs_data[9], 9'h000);
        run_full(5'h03, "B");
        chk("B_w9_addr", obs_addr[9], 7'h08);
        chk("B_w9_data", obs_data[9], 9'h006);

        // Write 4 (reg 0x02) is never acknowledged.
        drop_en = 1; drop_addr = 7'h02;
        do_start(5'($urandom_range(0, 31)));
        wait_flag(1'b1, 4000, got);
        err_t = $time;
        lat = int'((err_t - obs_t[4]) / PERIOD);
        chk("C_timeout_min", lat >= TO, 1'b1);
        chk("C_timeout_max", lat <= TO + 2, 1'b1);
        chk("C_step", step, 4'd4);
        chk("C_oe", output_en, 1'b0);
        chk("C_busy", seq_busy, 1'b0);
        chk("C_done", seq_done, 1'b0);
        chk("C_writes", wr_idx, 5);
        $display("C: timeout after %0d cycles at step %0d", lat, step);
        drop_en = 0;
        run_full(5'($urandom_range(0, 31)), "C_restart");

        // Reset in the power-up delay after write 0.
        do_start(5'h11);
        for (int i = 0; i < 200 && !(wr_idx >= 1 && !controller_busy); i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("D_busy_before", seq_busy, 1'b1);
        chk("D_writes_before", wr_idx, 1);
        #2 reset = 1'b0;
        #1;
        chk("D_async_busy", seq_busy, 1'b0);
        chk("D_async_step", step, 4'd0);
        chk("D_async_addr", codec_reg_addr, 7'h00);
        chk("D_async_oe", output_en, 1'b0);
        quiet = 1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (PW + 40) @(negedge clk);
        quiet = 0;
        chk("D_idle_busy", seq_busy, 1'b0);
        chk("D_idle_done", seq_done, 1'b0);
        $display("D: reset mid-delay, no writes afterwards");
        run_full(5'h1F, "D_restart");

        // A second start mid-sequence must not restart or resample the rate.
        f1 = 5'($urandom_range(0, 31));
        f2 = ~f1;
        do_start(f1);
        for (int i = 0; i < 500 && wr_idx < 3; i++) @(negedge clk);
        frequency = f2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_flag(1'b0, 3000, got);
        check_done("E");
        chk("E_w9_data", obs_data[9], {3'b000, f1, 1'b0});

        for (int r = 0; r < 4; r++) run_full(5'($urandom_range(0, 31)), "R");

`ifdef READBACK_VERIFY_EN
        // Register 0x00 reads back wrong: fails at step 2 before reg 0x01 is written.
        corrupt_en = 1;
        do_start(5'h00);
        wait_flag(1'b1, 3000, got);
        chk("F_step", step, 4'd2);
        chk("F_writes", wr_idx, 3);
        chk("F_reads", rd_cnt, 2);
        chk("F_oe", output_en, 1'b0);
        $display("F: readback mismatch at step %0d", step);
        corrupt_en = 0;
        run_full(5'h05, "F_restart");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
